div_unit: RTL
=============

# div_unit

Multi-cycle 32-bit integer divider serving the execute stage for DIV/DIVU. The execute stage initiates a divide with a start/operand handshake and holds it until this block responds with a 64-bit {remainder, quotient} result and a ready flag. The execute stage then forwards the result to the hi/lo write port: hi receives the remainder and lo receives the quotient. A restoring shift-subtract algorithm produces one quotient bit per cycle, and the execute stage stalls the pipeline while the divide runs.

## Interface
- No parameters. Operand width is fixed at 32 bits and the result width at 64 bits.
- i_clk        input   1   clock; every state change occurs on the rising edge.
- i_rst_n      input   1   reset, synchronous and active-low.
- i_signed_div input   1   1 = signed divide (DIV), 0 = unsigned divide (DIVU). Sampled together with i_start.
- i_opdata_0   input   32  dividend. Sampled only on the accepting edge.
- i_opdata_1   input   32  divisor. Sampled only on the accepting edge.
- i_start      input   1   divide request, level-sensitive. The initiator holds it high until it sees o_ready.
- i_annul      input   1   cancel request, e.g. on a pipeline flush.
- o_result     output  64  {remainder[63:32], quotient[31:0]}. Registered.
- o_ready      output  1   result valid. Registered.

## Operation
- State register has four states: IDLE, BYZERO, ON, END.
- IDLE:
  - Condition: i_start=1, i_annul=0, i_opdata_1≠0. Latch the operands and i_signed_div, clear the 6-bit iteration counter, go to ON.
  - Condition: i_start=1, i_annul=0, i_opdata_1=0. Go to BYZERO.
  - Otherwise stay in IDLE.
- BYZERO: unconditionally go to END with o_result=64'h0.
- Operand preparation on accept:
  - If signed and an operand is negative, store its two's-complement magnitude. Otherwise store it unchanged.
  - Record the sign of each original operand.
- ON, with i_annul=0, performs one iteration per cycle:
  - Working register is 65 bits: {partial remainder[64:32], dividend/quotient shift[31:0]}. On accept it holds {33'b0, |dividend|}.
  - Each cycle: shift left by 1. Compute diff = upper 33 bits − {1'b0, |divisor|}.
  - If diff is non-negative (bit 32 = 0), replace the upper bits with diff and shift in quotient bit 1. Otherwise shift in 0.
  - Counter increments each cycle. After the 32nd iteration, go to END.
- Sign fix-up, applied on the edge that enters END from ON:
  - Quotient is negated if signed and the operand signs differ.
  - Remainder is negated if signed and the dividend was negative. The remainder always takes the sign of the dividend.
  - Corner case: signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and remainder 0 (wrap-around, no trap).
- ON with i_annul=1: go to IDLE on the next edge. o_ready stays 0 and o_result stays 0.
- END:
  - o_ready=1 and o_result holds the final value.
  - i_start=1: stay in END and keep the result stable.
  - i_start=0: go to IDLE, clear o_ready and o_result.
  - i_annul is ignored in END and BYZERO.
- Operand inputs may change freely after the accepting edge without affecting the divide in flight.

## Timing
- Reset: when i_rst_n=0 at a rising edge, the next state is IDLE. This holds in every state, including mid-divide, and discards any partial result.
  - Reset values: o_ready=0, o_result=64'h0, counter=0.
- Label the accepting edge E0.
- Nonzero divisor:
  - ON covers E1..E32.
  - o_ready=1 is visible in the cycle after E32, which is 33 cycles after the request was sampled.
- Zero divisor: BYZERO follows E0, END is entered at E1, and o_ready=1 is visible after E1.
- o_ready stays high for as long as i_start stays high. The initiator drops i_start in the cycle it observes o_ready=1. One edge later, o_ready=0.
- Back-to-back divides: a new request is accepted only from IDLE, so there is at least one IDLE cycle between consecutive divides.
- Counter: 6 bits, terminal count 32, with no wrap-around within a divide.

## Test plan
- Unsigned: 0xFFFFFFFF / 0x00000002 → o_result = {0x00000001, 0x7FFFFFFF}, o_ready rising 33 cycles after the accepting edge.
- Signed: 0xFFFFFFF9 (−7) / 0x00000002 → {0xFFFFFFFF, 0xFFFFFFFD}. Also 7 / −2 → {0x00000001, 0xFFFFFFFD}.
- Divide by zero: 0x12345678 / 0 in both signed and unsigned mode → o_ready 2 cycles after the accepting edge, o_result=0. Hold i_start for 3 more cycles → o_ready stays 1, result stable.
- Annul: start 100/7, assert i_annul at iteration 10 → IDLE next cycle, o_ready never rises. A new request 100/7 then returns {0x00000002, 0x0000000E}.
- Reset mid-divide: assert i_rst_n=0 at iteration 20 → all outputs 0 on the next edge. After release, 0x80000000 / 0xFFFFFFFF signed returns {0x00000000, 0x80000000}.
- Handshake: drop i_start in the first ready cycle → o_ready=0 on the next edge. Change the operands during ON → result unaffected.

Source files
------------

// File: rtl/div_unit.sv
// div_unit: multi-cycle 32-bit restoring divider for DIV/DIVU.
// Result is {remainder, quotient}. One quotient bit is produced per cycle.
// A zero divisor short-circuits through BYZERO and returns an all-zero result.
module div_unit (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_signed_div,
    input  logic [31:0] i_opdata_0,
    input  logic [31:0] i_opdata_1,
    input  logic        i_start,
    input  logic        i_annul,
    output logic [63:0] o_result,
    output logic        o_ready
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BYZERO = 2'd1,
        S_ON     = 2'd2,
        S_END    = 2'd3
    } state_t;

    localparam logic [5:0] LAST_ITER = 6'd31;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [64:0] work_q, work_d;       // {partial remainder, dividend/quotient shift}
    logic [31:0] dvs_q, dvs_d;         // divisor magnitude
    logic        sgn_q, sgn_d;
    logic        neg_a_q, neg_a_d;     // dividend was negative
    logic        neg_b_q, neg_b_d;     // divisor was negative
    logic [63:0] result_q, result_d;
    logic        ready_q, ready_d;

    logic [31:0] mag_a, mag_b;
    logic [64:0] shifted, step;
    logic [32:0] diff;
    logic [31:0] quo_fix, rem_fix;

    // Next-state, datapath iteration and sign fix-up.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        work_d   = work_q;
        dvs_d    = dvs_q;
        sgn_d    = sgn_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        result_d = result_q;
        ready_d  = ready_q;

        // Operand magnitudes: only negated when a signed divide sees a negative operand.
        mag_a = (i_signed_div && i_opdata_0[31]) ? (~i_opdata_0 + 32'd1) : i_opdata_0;
        mag_b = (i_signed_div && i_opdata_1[31]) ? (~i_opdata_1 + 32'd1) : i_opdata_1;

        // One restoring step: shift, trial-subtract, keep the difference if non-negative.
        shifted = work_q << 1;
        diff    = shifted[64:32] - {1'b0, dvs_q};
        step    = diff[32] ? shifted : {diff, shifted[31:1], 1'b1};

        // Quotient negative when signs differ; remainder follows the dividend's sign.
        quo_fix = (sgn_q && (neg_a_q ^ neg_b_q)) ? (~step[31:0] + 32'd1) : step[31:0];
        rem_fix = (sgn_q && neg_a_q) ? (~step[63:32] + 32'd1) : step[63:32];

        case (state_q)
            S_IDLE: begin
                if (i_start && !i_annul) begin
                    if (i_opdata_1 != 32'd0) begin
                        work_d  = {33'd0, mag_a};
                        dvs_d   = mag_b;
                        sgn_d   = i_signed_div;
                        neg_a_d = i_opdata_0[31];
                        neg_b_d = i_opdata_1[31];
                        cnt_d   = 6'd0;
                        state_d = S_ON;
                    end else begin
                        state_d = S_BYZERO;
                    end
                end
            end
            S_BYZERO: begin
                result_d = 64'd0;
                ready_d  = 1'b1;
                state_d  = S_END;
            end
            S_ON: begin
                if (i_annul) begin
                    state_d = S_IDLE;
                end else begin
                    work_d = step;
                    cnt_d  = cnt_q + 6'd1;
                    if (cnt_q == LAST_ITER) begin
                        result_d = {rem_fix, quo_fix};
                        ready_d  = 1'b1;
                        state_d  = S_END;
                    end
                end
            end
            S_END: begin
                // Result held until the initiator releases its request.
                if (!i_start) begin
                    result_d = 64'd0;
                    ready_d  = 1'b0;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= 6'd0;
            work_q   <= 65'd0;
            dvs_q    <= 32'd0;
            sgn_q    <= 1'b0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            result_q <= 64'd0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            work_q   <= work_d;
            dvs_q    <= dvs_d;
            sgn_q    <= sgn_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            result_q <= result_d;
            ready_q  <= ready_d;
        end
    end

    assign o_result = result_q;
    assign o_ready  = ready_q;

endmodule
